// File: rtl/rv_pkg.sv
// Width helpers shared by the rv_* ready/valid building blocks.
package rv_pkg;

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int rv_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to index depth entries, never less than one.
  function automatic int rv_pw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rv_ring_ptr.sv
// Ring index register with synchronous clear, increment enable and explicit
// wrap from DEPTH-1 to 0, so DEPTH need not be a power of two.
module rv_ring_ptr
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      inc,
  output logic [rv_pw(DEPTH)-1:0]   ptr
);

  localparam int PW = rv_pw(DEPTH);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rv_fifo_arr_gate.sv
// DEPTH-entry ready/valid FIFO of N lanes x DW bits with gated acceptance,
// flush, occupancy count and almost_full. Optional: RV_FIFO_ARR_BYPASS_EN.
module rv_fifo_arr_gate
  import rv_pkg::*;
#(
  parameter int N         = 1,
  parameter int DW        = 32,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DW-1:0]             s_data [0:N-1],
  input  logic                      gate_accept,
  input  logic                      flush,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DW-1:0]             m_data [0:N-1],
  output logic [rv_cw(DEPTH)-1:0]   count,
  output logic                      almost_full
);

  localparam int CW = rv_cw(DEPTH);
  localparam int PW = rv_pw(DEPTH);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic live;
  logic fifo_valid;
  logic push;
  logic pop_fifo;
  logic byp_take;
  logic wr_en;

  // Output-side qualifiers look only at registered state and the local
  // control inputs; m_ready never feeds s_ready.
  assign live        = rst_n && !flush;
  assign s_ready     = live && gate_accept && (count_q != CW'(DEPTH));
  assign fifo_valid  = live && (count_q != '0);
  assign almost_full = rst_n && (count_q >= CW'(AF_THRESH));
  assign push        = s_valid && s_ready;
  assign pop_fifo    = fifo_valid && m_ready;
  assign wr_en       = push && !byp_take;
  assign count       = count_q;

`ifdef RV_FIFO_ARR_BYPASS_EN
  logic byp_path;

  // Empty queue: the upstream beat is presented directly and, if taken
  // downstream in the same cycle, never touches storage.
  assign byp_path = live && (count_q == '0);
  assign m_valid  = byp_path ? (s_valid && gate_accept) : fifo_valid;
  assign byp_take = byp_path && s_valid && gate_accept && m_ready;
`else
  assign m_valid  = fifo_valid;
  assign byp_take = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [DW-1:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (wr_en) begin
          lane_mem[wr_ptr] <= s_data[gi];
        end
      end

`ifdef RV_FIFO_ARR_BYPASS_EN
      assign m_data[gi] = byp_path ? s_data[gi] : lane_mem[rd_ptr];
`else
      assign m_data[gi] = lane_mem[rd_ptr];
`endif
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (wr_en && !pop_fifo) begin
      count_d = count_q + CW'(1);
    end else if (pop_fifo && !wr_en) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  rv_ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  rv_ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop_fifo),
    .ptr   (rd_ptr)
  );

endmodule

// File: tb/tb_rv_fifo_arr_gate.sv
// Directed vector bench for rv_fifo_arr_gate at N=2, DW=8, DEPTH=4.
module tb_rv_fifo_arr_gate;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data [0:1];
  logic       gate_accept;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data [0:1];
  logic [2:0] count;
  logic       almost_full;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv_fifo_arr_gate #(.N(2), .DW(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .gate_accept (gate_accept),
    .flush       (flush),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .count       (count),
    .almost_full (almost_full)
  );

  typedef struct {
    logic       rst_n, sv, ga, fl, mr;
    logic [7:0] d0, d1;
    logic       e_sr, e_mv;
    logic [7:0] e0, e1;
    logic [2:0] e_cnt;
    logic       e_af;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic sv, input logic ga, input logic fl,
                     input logic mr, input logic [7:0] d0, input logic [7:0] d1,
                     input logic sr, input logic mv, input logic [7:0] e0,
                     input logic [7:0] e1, input logic [2:0] cnt, input logic af);
    vec_t v;
    v.rst_n = r; v.sv = sv; v.ga = ga; v.fl = fl; v.mr = mr;
    v.d0 = d0; v.d1 = d1; v.e_sr = sr; v.e_mv = mv;
    v.e0 = e0; v.e1 = e1; v.e_cnt = cnt; v.e_af = af;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic sv, input logic ga, input logic fl,
                       input logic mr, input logic [7:0] d0, input logic [7:0] d1);
    rst_n = r; s_valid = sv; gate_accept = ga; flush = fl; m_ready = mr;
    s_data[0] = d0; s_data[1] = d1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);

`ifndef RV_FIFO_ARR_BYPASS_EN
    // reset state
    add(0,0,1,0,0, 8'h00,8'h00, 0,0, 8'h00,8'h00, 0,0);
    // fill with m_ready low; 5th beat held
    add(1,1,1,0,0, 8'h11,8'h22, 1,0, 8'h00,8'h00, 0,0);
    add(1,1,1,0,0, 8'h33,8'h44, 1,1, 8'h11,8'h22, 1,0);
    add(1,1,1,0,0, 8'h55,8'h66, 1,1, 8'h11,8'h22, 2,0);
    add(1,1,1,0,0, 8'h77,8'h88, 1,1, 8'h11,8'h22, 3,1);
    add(1,1,1,0,0, 8'h99,8'hAA, 0,1, 8'h11,8'h22, 4,1);
    // drain in order
    add(1,0,1,0,1, 8'h00,8'h00, 0,1, 8'h11,8'h22, 4,1);
    add(1,0,1,0,1, 8'h00,8'h00, 1,1, 8'h33,8'h44, 3,1);
    add(1,0,1,0,1, 8'h00,8'h00, 1,1, 8'h55,8'h66, 2,0);
    add(1,0,1,0,1, 8'h00,8'h00, 1,1, 8'h77,8'h88, 1,0);
    add(1,0,1,0,1, 8'h00,8'h00, 1,0, 8'h00,8'h00, 0,0);
    // sustained streaming, pointers wrap several times
    add(1,1,1,0,1, 8'd0,8'h80, 1,0, 8'h00,8'h00, 0,0);
    for (int k = 1; k < 16; k++)
      add(1,1,1,0,1, 8'(k),8'(k+128), 1,1, 8'(k-1),8'(k+127), 1,0);
    add(1,0,1,0,1, 8'h00,8'h00, 1,1, 8'd15,8'h8F, 1,0);
    add(1,0,1,0,0, 8'h00,8'h00, 1,0, 8'h00,8'h00, 0,0);
    // gate_accept low blocks pushes, drain continues
    add(1,1,1,0,0, 8'hA1,8'hB1, 1,0, 8'h00,8'h00, 0,0);
    add(1,1,1,0,0, 8'hA2,8'hB2, 1,1, 8'hA1,8'hB1, 1,0);
    add(1,1,1,0,0, 8'hA3,8'hB3, 1,1, 8'hA1,8'hB1, 2,0);
    add(1,1,0,0,1, 8'hEE,8'hEE, 0,1, 8'hA1,8'hB1, 3,1);
    add(1,1,0,0,1, 8'hEE,8'hEE, 0,1, 8'hA2,8'hB2, 2,0);
    add(1,1,0,0,1, 8'hEE,8'hEE, 0,1, 8'hA3,8'hB3, 1,0);
    add(1,1,0,0,1, 8'hEE,8'hEE, 0,0, 8'h00,8'h00, 0,0);
    add(1,1,1,0,0, 8'hC1,8'hD1, 1,0, 8'h00,8'h00, 0,0);
    add(1,0,1,0,0, 8'h00,8'h00, 1,1, 8'hC1,8'hD1, 1,0);
    add(1,0,1,0,1, 8'h00,8'h00, 1,1, 8'hC1,8'hD1, 1,0);
    // flush at count 3 with both sides willing
    add(1,1,1,0,0, 8'hD1,8'hE1, 1,0, 8'h00,8'h00, 0,0);
    add(1,1,1,0,0, 8'hD2,8'hE2, 1,1, 8'hD1,8'hE1, 1,0);
    add(1,1,1,0,0, 8'hD3,8'hE3, 1,1, 8'hD1,8'hE1, 2,0);
    add(1,1,1,1,1, 8'hD4,8'hE4, 0,0, 8'h00,8'h00, 3,1);
    add(1,0,1,0,0, 8'h00,8'h00, 1,0, 8'h00,8'h00, 0,0);
    // reset mid-stream at count 2
    add(1,1,1,0,0, 8'hE1,8'hF1, 1,0, 8'h00,8'h00, 0,0);
    add(1,1,1,0,0, 8'hE2,8'hF2, 1,1, 8'hE1,8'hF1, 1,0);
    add(0,1,1,0,1, 8'hE3,8'hF3, 0,0, 8'h00,8'h00, 2,0);
    add(1,1,1,0,0, 8'hF1,8'h1F, 1,0, 8'h00,8'h00, 0,0);
    add(1,0,1,0,1, 8'h00,8'h00, 1,1, 8'hF1,8'h1F, 1,0);
    add(1,0,1,0,0, 8'h00,8'h00, 1,0, 8'h00,8'h00, 0,0);
`else
    add(0,0,1,0,0, 8'h00,8'h00, 0,0, 8'h00,8'h00, 0,0);
    // empty: zero-latency pass-through, consumed without storage
    add(1,1,1,0,1, 8'hA5,8'h5A, 1,1, 8'hA5,8'h5A, 0,0);
    add(1,1,1,0,1, 8'hA6,8'h6A, 1,1, 8'hA6,8'h6A, 0,0);
    // not taken downstream: written normally
    add(1,1,1,0,0, 8'hB7,8'h7B, 1,1, 8'hB7,8'h7B, 0,0);
    add(1,0,1,0,1, 8'h00,8'h00, 1,1, 8'hB7,8'h7B, 1,0);
    add(1,1,0,0,1, 8'hCC,8'hCC, 0,0, 8'h00,8'h00, 0,0);
    add(1,0,1,0,0, 8'h00,8'h00, 1,0, 8'h00,8'h00, 0,0);
`endif

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].rst_n, vq[i].sv, vq[i].ga, vq[i].fl, vq[i].mr, vq[i].d0, vq[i].d1);
      #1;
      $display("vec %0d: rst_n=%0b sv=%0b ga=%0b fl=%0b mr=%0b d=%02h/%02h -> sr=%0b mv=%0b m=%02h/%02h cnt=%0d af=%0b",
               i, rst_n, s_valid, gate_accept, flush, m_ready, s_data[0], s_data[1],
               s_ready, m_valid, m_data[0], m_data[1], count, almost_full);
      chk($sformatf("v%0d s_ready", i), int'(s_ready), int'(vq[i].e_sr));
      chk($sformatf("v%0d m_valid", i), int'(m_valid), int'(vq[i].e_mv));
      chk($sformatf("v%0d count", i), int'(count), int'(vq[i].e_cnt));
      chk($sformatf("v%0d almost_full", i), int'(almost_full), int'(vq[i].e_af));
      if (vq[i].e_mv) begin
        chk($sformatf("v%0d m_data0", i), int'(m_data[0]), int'(vq[i].e0));
        chk($sformatf("v%0d m_data1", i), int'(m_data[1]), int'(vq[i].e1));
      end
    end

`ifndef RV_FIFO_ARR_BYPASS_EN
    // Hold stability under backpressure, then a bounded drain wait.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5C, 8'hC5);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int c = 0; c < 3; c++) begin
      #1;
      $display("hold %0d: mv=%0b m=%02h/%02h cnt=%0d", c, m_valid, m_data[0], m_data[1], count);
      chk($sformatf("hold%0d m_valid", c), int'(m_valid), 1);
      chk($sformatf("hold%0d m_data0", c), int'(m_data[0]), 'h5C);
      chk($sformatf("hold%0d m_data1", c), int'(m_data[1]), 'hC5);
      @(negedge clk);
    end
    m_ready = 1'b1;
    begin
      int waited;
      waited = 0;
      #1;
      while (m_valid && waited < 10) begin
        @(negedge clk);
        #1;
        waited++;
      end
      $display("drain: waited %0d cycles, cnt=%0d", waited, count);
      chk("drain_within_bound", int'(waited < 10), 1);
      chk("drain_count", int'(count), 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_fifo_arr_gate.md
Name: rv_fifo_arr_gate

Overview:
- Parametrised successor to the single-entry array skid stage.
- A DEPTH-entry ready/valid FIFO carrying N lanes of DW bits per beat.
- Upstream acceptance is gated by `gate_accept`. Adds synchronous `flush`, an occupancy count and an almost-full flag.
- Sits between QMC/LSM pipeline stages where more than one beat of elasticity is needed, e.g. ahead of regression/accumulator stages with multi-cycle backpressure.

Parameters:
- N, 1, number of data lanes per beat
- DW, 32, bits per lane
- DEPTH, 4, number of storage entries (≥2, need not be a power of two)
- AF_THRESH, DEPTH-1, `almost_full` asserts when count ≥ AF_THRESH (1..DEPTH)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  upstream beat valid
- s_ready  out  1  upstream beat accepted this cycle
- s_data  in  N x DW  unpacked array [0:N-1] of upstream lanes
- gate_accept  in  1  acceptance enable; 0 blocks new writes, drain continues
- flush  in  1  synchronous discard of all stored beats
- m_valid  out  1  downstream beat valid
- m_ready  in  1  downstream ready
- m_data  out  N x DW  unpacked array [0:N-1] of the head beat
- count  out  $clog2(DEPTH+1)  current occupancy
- almost_full  out  1  count ≥ AF_THRESH

Behaviour:
- Reset:
  - rst_n sampled low at a clk edge clears rd_ptr, wr_ptr and count to 0.
  - While rst_n is low, s_ready=0, m_valid=0, almost_full=0.
  - Storage contents are don't-care, not reset.
  - Reset mid-stream drops all beats; there is no partial-beat state.
- Storage: ring of DEPTH entries, each N x DW. Pointers wrap from DEPTH-1 to 0 explicitly (no reliance on power-of-two overflow).
- s_ready = rst_n && !flush && gate_accept && (count != DEPTH).
  - No combinational dependence on m_ready.
  - When full, a pop does not enable a same-cycle push.
- push = s_valid && s_ready: write s_data to entry[wr_ptr], then advance wr_ptr.
- pop = m_valid && m_ready (FIFO path): advance rd_ptr.
- m_valid = (count != 0) and not flushing. m_data = entry[rd_ptr], held stable while m_valid && !m_ready.
- Count update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
  - count never exceeds DEPTH and never underflows.
- Latency (macro off): a beat written at edge t is visible on m_valid/m_data in the cycle after t. Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle sustained when 0 < count < DEPTH.
- flush:
  - Has priority over push and pop. At the edge, pointers and count go to 0.
  - While flush=1, s_ready=0 and m_valid=0, so no handshake completes.
- gate_accept=0 only blocks pushes. Stored beats keep draining.
- almost_full is registered-equivalent: a combinational compare of the registered count, so it carries no m_ready path.

Optional Feature:
- Macro: RV_FIFO_ARR_BYPASS_EN.
- Defined:
  - When count==0 and not flushing: m_valid = s_valid && gate_accept and m_data = s_data (zero-latency pass-through).
  - If m_ready is also high, the beat is consumed without being written; pointers and count are unchanged.
  - If m_ready is low, the beat is written normally.
  - s_ready is unchanged from the base definition.
- Undefined: no input-to-output combinational path; minimum latency is 1 cycle as above.

Decomposition:
- Shared package rv_pkg:
  - function rv_cw(depth) returning $clog2(depth+1)
  - function rv_pw(depth) returning max(1,$clog2(depth))
  - reused by other rv_* helpers
- One natural sub-module, rv_ring_ptr (parameter DEPTH): a pointer register with synchronous clear, increment enable and explicit wrap. Instantiated twice, for rd and wr.

Test Plan:
1. N=2, DW=8, DEPTH=4, m_ready=0. Push {0x11,0x22}, {0x33,0x44}, {0x55,0x66}, {0x77,0x88} → count 1,2,3,4; almost_full rises at count=3; s_ready=0 at count=4; 5th beat held upstream.
2. From full, m_ready=1 for 4 cycles with s_valid=0 → beats emerge in order 0x11/0x22 … 0x77/0x88; count 3,2,1,0; m_valid drops after the 4th pop.
3. Sustained s_valid=1, m_ready=1, ascending lane-0 data 0..15 → output 0..15 in order, no gaps after the first beat, count steady at 1 (macro off) or 0 (macro on).
4. Count=3 with gate_accept=0 and s_valid=1 → no push, s_ready=0, drain continues to count=0; re-assert gate_accept → pushes resume next cycle.
5. Count=3, assert flush for 1 cycle with s_valid=1 and m_ready=1 → no handshake that cycle, count=0 next cycle, m_valid=0, s_ready returns to 1.
6. Count=2, rst_n low for 1 cycle → count=0, m_valid=0, s_ready=0 during reset; first push afterwards emerges as the next m_data. With RV_FIFO_ARR_BYPASS_EN: empty, s_valid=1, m_ready=1, data 0xA5 → m_valid and m_data=0xA5 in the same cycle, count stays 0.
